// File: rtl/fir_stream_driver_if.sv
// Sample, config and result signals between the FIR stream driver (master)
// and its surroundings: upstream source, config source, FIR core, result sink.
interface fir_stream_driver_if #(
   parameter int TAP_SIZE    = 3,
   parameter int NBR_OF_TAPS = 3,
   parameter int X_N_SIZE    = 8,
   parameter int Y_N_SIZE    = 11
);
   logic signed [X_N_SIZE-1:0]         s_data;
   logic                               s_valid;
   logic                               s_ready;
   logic                               cfg_req;
   logic [NBR_OF_TAPS*TAP_SIZE-1:0]    cfg_taps;
   logic                               cfg_done;
   logic signed [X_N_SIZE-1:0]         fir_x_n;
   logic                               fir_tvalid;
   logic                               fir_set_coeffs;
   logic signed [Y_N_SIZE-1:0]         fir_y_n;
   logic                               m_y_valid;
   logic signed [Y_N_SIZE-1:0]         m_y_data;
   logic                               busy;

   modport master (
      input  s_data, s_valid, cfg_req, cfg_taps, fir_y_n,
      output s_ready, cfg_done, fir_x_n, fir_tvalid, fir_set_coeffs,
             m_y_valid, m_y_data, busy
   );

   modport slave (
      output s_data, s_valid, cfg_req, cfg_taps, fir_y_n,
      input  s_ready, cfg_done, fir_x_n, fir_tvalid, fir_set_coeffs,
             m_y_valid, m_y_data, busy
   );
endinterface

// File: rtl/fir_stream_driver.sv
// Drives the FIR core's x_n/tvalid/set_coeffs in lockstep with its
// GET_DATA/CALC/SET_OUTPUT/CONFIG sequence and strobes out each new result.
module fir_stream_driver #(
   parameter int TAP_SIZE    = 3,
   parameter int NBR_OF_TAPS = 3,
   parameter int X_N_SIZE    = 8,
   parameter int Y_N_SIZE    = 11,
   parameter int BOOT_CYCLES = 4
) (
   input logic                 clk,
   input logic                 reset,
   fir_stream_driver_if.master bus
);
   localparam int FRAME = NBR_OF_TAPS + 3;
   localparam int PW    = $clog2(FRAME);
   localparam int BW    = $clog2(BOOT_CYCLES + 1);
   localparam int CW    = $clog2(NBR_OF_TAPS + 1);

   localparam logic [PW-1:0] P_LAST   = PW'(FRAME - 1);
   localparam logic [BW-1:0] B_LAST   = BW'(BOOT_CYCLES - 1);
   localparam logic [CW-1:0] CFG_LAST = CW'(NBR_OF_TAPS - 1);

   typedef enum logic [2:0] {BOOT, IDLE, ARM, STREAM, DRAIN, CFG, CFG_TAIL} state_t;

   state_t                state, state_nx;
   logic [BW-1:0]         boot_cnt;
   logic [PW-1:0]         phase;
   logic [CW-1:0]         cfg_cnt;
   logic                  full;
   logic [X_N_SIZE-1:0]   held;
   logic                  result_pending;

   logic [X_N_SIZE-1:0]   x_n_nx;
   logic                  tvalid_nx, set_nx, done_nx, consume, capture;
   logic [TAP_SIZE-1:0]   tap_sel;
   int                    tap_idx;

   // cfg_done is high during the first IDLE cycle; the requester may still
   // be holding cfg_req then, so that cycle must not start another load.
   logic cfg_start;
   assign cfg_start   = bus.cfg_req && !bus.cfg_done;
   assign bus.s_ready = ~full;

   always_comb begin
      state_nx = state;
      unique case (state)
         BOOT:     if (boot_cnt == B_LAST) state_nx = IDLE;
         IDLE:     if (cfg_start) state_nx = CFG;
                   else if (full) state_nx = ARM;
         ARM:      state_nx = STREAM;
         STREAM:   if (phase == P_LAST && !full) state_nx = DRAIN;
         DRAIN:    state_nx = IDLE;
         CFG:      if (cfg_cnt == CFG_LAST) state_nx = CFG_TAIL;
         CFG_TAIL: state_nx = IDLE;
         default:  state_nx = BOOT;
      endcase
   end

   // Taps go out highest first; c0 is the core's final shift in CFG_TAIL.
   assign tap_idx = NBR_OF_TAPS - 1 - int'(cfg_cnt);
   assign tap_sel = bus.cfg_taps[tap_idx*TAP_SIZE +: TAP_SIZE];

   always_comb begin
      x_n_nx    = bus.fir_x_n;
      tvalid_nx = bus.fir_tvalid;
      set_nx    = 1'b0;
      done_nx   = 1'b0;
      consume   = 1'b0;
      capture   = result_pending &&
                  ((state == STREAM && phase == '0) || state == DRAIN);
      unique case (state)
         IDLE: begin
            if (cfg_start) begin
               x_n_nx    = '0;
               tvalid_nx = 1'b0;
               set_nx    = 1'b1;
            end else if (full) begin
               x_n_nx    = held;
               tvalid_nx = 1'b1;
               consume   = 1'b1;
            end
         end
         STREAM: begin
            if (phase == P_LAST) begin
               if (full) begin
                  x_n_nx  = held;
                  consume = 1'b1;
               end else begin
                  x_n_nx    = '0;
                  tvalid_nx = 1'b0;
               end
            end
         end
         CFG: begin
            set_nx = (cfg_cnt != CFG_LAST);
            x_n_nx = '0;
            x_n_nx[TAP_SIZE-1:0] = tap_sel;
         end
         CFG_TAIL: begin
            x_n_nx  = '0;
            done_nx = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state              <= BOOT;
         boot_cnt           <= '0;
         phase              <= '0;
         cfg_cnt            <= '0;
         full               <= 1'b0;
         held               <= '0;
         result_pending     <= 1'b0;
         bus.fir_x_n        <= '0;
         bus.fir_tvalid     <= 1'b0;
         bus.fir_set_coeffs <= 1'b0;
         bus.cfg_done       <= 1'b0;
         bus.m_y_valid      <= 1'b0;
         bus.m_y_data       <= '0;
         bus.busy           <= 1'b0;
      end else begin
         state    <= state_nx;
         boot_cnt <= (state == BOOT) ? boot_cnt + BW'(1) : '0;
         phase    <= (state == STREAM && phase != P_LAST) ? phase + PW'(1) : '0;
         cfg_cnt  <= (state == CFG) ? cfg_cnt + CW'(1) : '0;

         if (consume)
            full <= 1'b0;
         else if (bus.s_valid && !full) begin
            full <= 1'b1;
            held <= bus.s_data;
         end

         // Result appears on fir_y_n the cycle after SET_OUTPUT.
         if (capture)
            result_pending <= 1'b0;
         else if (state == STREAM && phase == P_LAST)
            result_pending <= 1'b1;
         bus.m_y_valid <= capture;
         if (capture) bus.m_y_data <= bus.fir_y_n;

         bus.fir_x_n        <= x_n_nx;
         bus.fir_tvalid     <= tvalid_nx;
         bus.fir_set_coeffs <= set_nx;
         bus.cfg_done       <= done_nx;
         bus.busy           <= (state_nx != IDLE);
      end
   end
endmodule

// File: tb/tb_fir_stream_driver.sv
// Directed bench for fir_stream_driver with a small behavioural model of the
// FIR core (3 taps, GET_DATA/4xCALC/SET_OUTPUT, shift-in config) on fir_y_n.
module tb_fir_stream_driver;
   localparam int TAP_SIZE    = 3;
   localparam int NBR_OF_TAPS = 3;
   localparam int X_N_SIZE    = 8;
   localparam int Y_N_SIZE    = 11;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   fir_stream_driver_if #(.TAP_SIZE(TAP_SIZE), .NBR_OF_TAPS(NBR_OF_TAPS),
                          .X_N_SIZE(X_N_SIZE), .Y_N_SIZE(Y_N_SIZE)) bus_if ();

   fir_stream_driver #(.TAP_SIZE(TAP_SIZE), .NBR_OF_TAPS(NBR_OF_TAPS),
                       .X_N_SIZE(X_N_SIZE), .Y_N_SIZE(Y_N_SIZE),
                       .BOOT_CYCLES(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   // Core model
   typedef enum logic [2:0] {C_IDLE, C_GET, C_CALC, C_SET, C_CFG} cst_t;
   cst_t                  cst;
   logic [1:0]            ccnt;
   logic signed [2:0]     t0, t1, t2;
   logic signed [7:0]     hx0, hx1, hx2;
   logic signed [10:0]    core_y;

   assign bus_if.fir_y_n = core_y;

   always_ff @(posedge clk) begin
      if (reset) begin
         cst    <= C_IDLE;
         ccnt   <= 2'd0;
         t0     <= -3'sd3;
         t1     <= 3'sd2;
         t2     <= 3'sd3;
         hx0    <= '0;
         hx1    <= '0;
         hx2    <= '0;
         core_y <= '0;
      end else begin
         case (cst)
            C_IDLE: if (bus_if.fir_set_coeffs) cst <= C_CFG;
                    else if (bus_if.fir_tvalid) cst <= C_GET;
            C_GET: begin
               if (bus_if.fir_tvalid) begin
                  hx2  <= hx1;
                  hx1  <= hx0;
                  hx0  <= bus_if.fir_x_n;
                  ccnt <= 2'd0;
                  cst  <= C_CALC;
               end else cst <= C_IDLE;
            end
            C_CALC: begin
               ccnt <= ccnt + 2'd1;
               if (ccnt == 2'd3) cst <= C_SET;
            end
            C_SET: begin
               core_y <= 11'(int'(t0)*int'(hx0) + int'(t1)*int'(hx1) + int'(t2)*int'(hx2));
               cst    <= C_GET;
            end
            C_CFG: begin
               t2 <= t1;
               t1 <= t0;
               t0 <= bus_if.fir_x_n[2:0];
               if (!bus_if.fir_set_coeffs) cst <= C_IDLE;
            end
            default: cst <= C_IDLE;
         endcase
      end
   end

   // Leaves the bench at the falling edge of boot cycle 0.
   task automatic apply_reset;
      reset           = 1'b1;
      bus_if.s_valid  = 1'b0;
      bus_if.s_data   = '0;
      bus_if.cfg_req  = 1'b0;
      bus_if.cfg_taps = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset           = 1'b1;
      bus_if.s_valid  = 1'b1;
      bus_if.s_data   = 8'sd9;
      bus_if.cfg_req  = 1'b1;
      bus_if.cfg_taps = '0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      n_checks++;
      if ({bus_if.fir_tvalid, bus_if.fir_set_coeffs, bus_if.cfg_done, bus_if.m_y_valid} !== 4'b0)
         $display("FAIL reset_ctrl: got tvalid/set/done/yvalid=%b expected 0000",
                  {bus_if.fir_tvalid, bus_if.fir_set_coeffs, bus_if.cfg_done, bus_if.m_y_valid});
      else n_pass++;
      n_checks++;
      if (bus_if.fir_x_n !== 8'sd0) $display("FAIL reset_x_n: got %0d expected 0", bus_if.fir_x_n);
      else n_pass++;
      n_checks++;
      if (bus_if.m_y_data !== 11'sd0) $display("FAIL reset_y_data: got %0d expected 0", bus_if.m_y_data);
      else n_pass++;
      n_checks++;
      if (bus_if.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus_if.busy);
      else n_pass++;
      n_checks++;
      if (bus_if.s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b expected 1", bus_if.s_ready);
      else n_pass++;
   endtask

   task automatic test_single_sample;
      int strobes, strobe_cyc, early;
      strobes = 0; strobe_cyc = -1; early = 0;
      apply_reset();
      for (int c = 0; c < 22; c++) begin
         if (c < 5 && bus_if.fir_tvalid) early++;
         if (c == 1) begin
            n_checks++;
            if (bus_if.s_ready !== 1'b0) $display("FAIL single_held: s_ready %b expected 0", bus_if.s_ready);
            else n_pass++;
         end
         if (c == 5) begin
            n_checks++;
            if (bus_if.fir_tvalid !== 1'b1 || cst != C_IDLE)
               $display("FAIL single_arm: tvalid %b at cycle 5 expected 1", bus_if.fir_tvalid);
            else n_pass++;
         end
         if (c == 6) begin
            n_checks++;
            if (cst != C_GET || bus_if.fir_x_n !== 8'sd1)
               $display("FAIL single_get: x_n %0d core_state %0d expected x_n 1 in GET_DATA", bus_if.fir_x_n, cst);
            else n_pass++;
         end
         if (c == 12) begin
            n_checks++;
            if (bus_if.fir_tvalid !== 1'b0) $display("FAIL single_drain: tvalid %b expected 0", bus_if.fir_tvalid);
            else n_pass++;
         end
         if (c == 13) begin
            n_checks++;
            if (bus_if.busy !== 1'b0) $display("FAIL single_busy: busy %b expected 0", bus_if.busy);
            else n_pass++;
         end
         if (bus_if.m_y_valid) begin
            strobes++;
            strobe_cyc = c;
            n_checks++;
            if (bus_if.m_y_data !== -11'sd3) $display("FAIL single_y: got %0d expected -3", bus_if.m_y_data);
            else n_pass++;
         end
         bus_if.s_valid = (c == 0);
         bus_if.s_data  = 8'sd1;
         @(negedge clk);
      end
      n_checks++;
      if (early != 0) $display("FAIL boot_tvalid: tvalid high %0d cycles during boot expected 0", early);
      else n_pass++;
      n_checks++;
      if (strobes != 1 || strobe_cyc != 13)
         $display("FAIL single_strobe: %0d strobes last at %0d expected 1 at 13", strobes, strobe_cyc);
      else n_pass++;
   endtask

   task automatic test_cfg_load;
      int sets, first_set, done_cyc, strobes;
      logic signed [7:0] xexp [4];
      xexp = '{8'sd0, 8'sd0, 8'sd0, 8'sd1};
      sets = 0; first_set = -1; done_cyc = -1; strobes = 0;
      apply_reset();
      bus_if.cfg_taps = {3'd0, 3'd0, 3'd1};
      for (int c = 0; c < 26; c++) begin
         if (bus_if.fir_set_coeffs) begin
            if (first_set < 0) first_set = c;
            sets++;
         end
         if (c >= 5 && c <= 8) begin
            n_checks++;
            if (bus_if.fir_x_n !== xexp[c-5])
               $display("FAIL cfg_x_n: cycle %0d got %0d expected %0d", c, bus_if.fir_x_n, xexp[c-5]);
            else n_pass++;
         end
         if (bus_if.cfg_done && done_cyc < 0) done_cyc = c;
         if (bus_if.m_y_valid) begin
            strobes++;
            n_checks++;
            if (c != 20 || bus_if.m_y_data !== 11'sd5)
               $display("FAIL cfg_y: cycle %0d data %0d expected cycle 20 data 5", c, bus_if.m_y_data);
            else n_pass++;
         end
         if (c == 0) bus_if.cfg_req = 1'b1;
         else if (bus_if.cfg_done) bus_if.cfg_req = 1'b0;
         bus_if.s_valid = (c == 10);
         bus_if.s_data  = 8'sd5;
         @(negedge clk);
      end
      n_checks++;
      if (sets != 3 || first_set != 5)
         $display("FAIL cfg_set_len: %0d cycles from %0d expected 3 from 5", sets, first_set);
      else n_pass++;
      n_checks++;
      if (done_cyc != 9) $display("FAIL cfg_done: at cycle %0d expected 9", done_cyc);
      else n_pass++;
      n_checks++;
      if (strobes != 1) $display("FAIL cfg_strobes: %0d expected 1", strobes);
      else n_pass++;
   endtask

   task automatic test_back_to_back;
      int idx, ng, ns;
      logic signed [7:0]  xv [3];
      logic signed [10:0] yv [3];
      xv = '{8'sd10, 8'sd20, 8'sd30};
      yv = '{-11'sd30, -11'sd40, -11'sd20};
      idx = 0; ng = 0; ns = 0;
      apply_reset();
      for (int c = 0; c < 32; c++) begin
         if (cst == C_GET && bus_if.fir_tvalid) begin
            n_checks++;
            if (ng >= 3 || c != 6 + 6*ng || bus_if.fir_x_n !== xv[ng])
               $display("FAIL b2b_get: #%0d at cycle %0d x %0d expected cycle %0d", ng, c, bus_if.fir_x_n, 6 + 6*ng);
            else n_pass++;
            ng++;
         end
         if (bus_if.m_y_valid) begin
            n_checks++;
            if (ns >= 3 || c != 13 + 6*ns || bus_if.m_y_data !== yv[ns])
               $display("FAIL b2b_y: #%0d at cycle %0d data %0d expected cycle %0d", ns, c, bus_if.m_y_data, 13 + 6*ns);
            else n_pass++;
            ns++;
         end
         if (c == 8) begin
            n_checks++;
            if (bus_if.s_ready !== 1'b0) $display("FAIL b2b_ready: s_ready %b expected 0", bus_if.s_ready);
            else n_pass++;
         end
         if (c == 25) begin
            n_checks++;
            if (bus_if.busy !== 1'b0 || bus_if.fir_tvalid !== 1'b0)
               $display("FAIL b2b_end: busy %b tvalid %b expected 0 0", bus_if.busy, bus_if.fir_tvalid);
            else n_pass++;
         end
         bus_if.s_valid = (idx < 3);
         bus_if.s_data  = (idx < 3) ? xv[idx] : 8'sd0;
         if (bus_if.s_valid && bus_if.s_ready) idx++;
         @(negedge clk);
      end
      n_checks++;
      if (ng != 3 || ns != 3) $display("FAIL b2b_count: gets %0d strobes %0d expected 3 3", ng, ns);
      else n_pass++;
   endtask

   task automatic test_cfg_midstream;
      int sets, first_set, strobes;
      sets = 0; first_set = -1; strobes = 0;
      apply_reset();
      bus_if.cfg_taps = {3'd0, 3'd0, 3'd2};
      for (int c = 0; c < 34; c++) begin
         if (bus_if.fir_set_coeffs) begin
            if (first_set < 0) first_set = c;
            sets++;
         end
         if (c == 17) begin
            n_checks++;
            if (bus_if.fir_x_n !== 8'sd2 || bus_if.fir_set_coeffs !== 1'b0)
               $display("FAIL mid_tail: x_n %0d set %b expected 2 0", bus_if.fir_x_n, bus_if.fir_set_coeffs);
            else n_pass++;
         end
         if (bus_if.m_y_valid) begin
            strobes++;
            n_checks++;
            if (!((c == 13 && bus_if.m_y_data === -11'sd12) || (c == 29 && bus_if.m_y_data === 11'sd6)))
               $display("FAIL mid_y: cycle %0d data %0d expected -12@13 or 6@29", c, bus_if.m_y_data);
            else n_pass++;
         end
         if (c == 8) bus_if.cfg_req = 1'b1;
         else if (bus_if.cfg_done) bus_if.cfg_req = 1'b0;
         bus_if.s_valid = (c == 0 || c == 19);
         bus_if.s_data  = (c == 0) ? 8'sd4 : 8'sd3;
         @(negedge clk);
      end
      n_checks++;
      if (first_set != 14 || sets != 3)
         $display("FAIL mid_set: %0d cycles from %0d expected 3 from 14", sets, first_set);
      else n_pass++;
      n_checks++;
      if (strobes != 2) $display("FAIL mid_strobes: %0d expected 2", strobes);
      else n_pass++;
   endtask

   task automatic test_reset_midstream;
      int strobes, early;
      strobes = 0; early = 0;
      apply_reset();
      for (int c = 0; c < 28; c++) begin
         if (c == 9) begin
            n_checks++;
            if (bus_if.fir_tvalid !== 1'b1 || bus_if.s_ready !== 1'b0)
               $display("FAIL rmid_pre: tvalid %b s_ready %b expected 1 0", bus_if.fir_tvalid, bus_if.s_ready);
            else n_pass++;
         end
         if (c == 10) begin
            n_checks++;
            if ({bus_if.fir_tvalid, bus_if.fir_set_coeffs, bus_if.busy, bus_if.m_y_valid, bus_if.s_ready} !== 5'b00001
                || bus_if.fir_x_n !== 8'sd0)
               $display("FAIL rmid_abort: tvalid/set/busy/yvalid/ready=%b x_n %0d expected 00001 0",
                        {bus_if.fir_tvalid, bus_if.fir_set_coeffs, bus_if.busy, bus_if.m_y_valid, bus_if.s_ready},
                        bus_if.fir_x_n);
            else n_pass++;
         end
         if (c >= 10 && bus_if.m_y_valid) strobes++;
         if (c >= 10 && c <= 14 && bus_if.fir_tvalid) early++;
         reset          = (c == 9);
         bus_if.s_valid = (c < 9);
         bus_if.s_data  = 8'sd7;
         @(negedge clk);
      end
      n_checks++;
      if (strobes != 0) $display("FAIL rmid_strobe: %0d strobes expected 0", strobes);
      else n_pass++;
      n_checks++;
      if (early != 0) $display("FAIL rmid_boot: tvalid high %0d cycles expected 0", early);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_sample();
      test_cfg_load();
      test_back_to_back();
      test_cfg_midstream();
      test_reset_midstream();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/fir_stream_driver.md
Name: fir_stream_driver

Overview:
- Feeder/collector on the far side of the FIR core's sample/config interface.
- Takes samples from an upstream valid/ready stream and coefficient-load requests from a control source.
- Generates the core's x_n, s_axis_fir_tvalid and s_set_coeffs with exact cycle alignment to the core's GET_DATA/CALC/SET_OUTPUT/CONFIG sequence.
- Captures each new o_y_n result into a one-cycle valid strobe for downstream logic.

Parameters:
- TAP_SIZE, 3, coefficient width; matches the core.
- NBR_OF_TAPS, 3, stored taps; sets the config length and frame period (NBR_OF_TAPS+3 = 6 cycles).
- X_N_SIZE, 8, sample width.
- Y_N_SIZE, 11, result width.
- BOOT_CYCLES, 4, cycles after reset release during which the core is in SETUP.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset; shared with the core.
- s_data  in  X_N_SIZE  signed upstream sample.
- s_valid  in  1  upstream sample valid.
- s_ready  out  1  high when the 1-entry sample holding register is empty.
- cfg_req  in  1  coefficient-load request; level, held until cfg_done.
- cfg_taps  in  NBR_OF_TAPS*TAP_SIZE  packed taps, c0 in LSBs.
- cfg_done  out  1  one-cycle pulse when taps are loaded.
- fir_x_n  out  X_N_SIZE  to core x_n; registered.
- fir_tvalid  out  1  to core s_axis_fir_tvalid; registered.
- fir_set_coeffs  out  1  to core s_set_coeffs; registered.
- fir_y_n  in  Y_N_SIZE  from core o_y_n.
- m_y_valid  out  1  one-cycle result strobe.
- m_y_data  out  Y_N_SIZE  captured result; holds between strobes.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0, except s_ready = 1. Holding register empty, state BOOT, boot counter 0, result_pending 0.
- Reset mid-operation aborts everything in one cycle. The held sample and pending cfg are discarded; cfg_req is re-sampled after BOOT.
- Holding register:
  - Loads on s_valid && s_ready.
  - Consumed only when its value is transferred into fir_x_n.
  - Load and consume in the same cycle are not possible: s_ready is 0 while full.
- States and transitions:
  - BOOT: count BOOT_CYCLES cycles, then go to IDLE. All core outputs stay 0.
  - IDLE:
    - If cfg_req, go to CFG. cfg has priority over samples.
    - Else if the register is full, go to ARM: fir_x_n <= held sample, consume it, fir_tvalid <= 1.
  - ARM: 1 cycle; the core sees tvalid in its IDLE. Go to STREAM with phase p=0. fir_x_n and fir_tvalid are held.
  - STREAM: phase counter p runs 0..5.
    - p=0 is the core's GET_DATA, where the core samples fir_x_n. p=1..4 is CALC. p=5 is SET_OUTPUT.
    - fir_tvalid stays 1 throughout.
    - At p=5, set result_pending.
    - At the end of p=5:
      - If the register is full: fir_x_n <= held sample, consume it, p <= 0.
      - Else: fir_tvalid <= 0, fir_x_n <= 0, go to DRAIN.
    - cfg_req arriving during STREAM is not serviced until the stream ends.
  - DRAIN: 1 cycle; the core is in GET_DATA with tvalid 0 and returns to IDLE. Go to IDLE.
  - CFG: NBR_OF_TAPS cycles k..k+2.
    - fir_set_coeffs = 1, fir_tvalid = 0.
    - fir_x_n = 0 at k, c2 at k+1, c1 at k+2.
  - CFG_TAIL: cycle k+3. fir_set_coeffs = 0, fir_x_n = c0 (the core's final shift). Then cycle k+4: IDLE with cfg_done = 1 for one cycle.
  - Result: core taps[0..2] = c0, c1, c2. Tap values are zero-extended from cfg_taps slices into fir_x_n LSBs; the core uses only the LSBs.
- Result capture:
  - In any cycle that is p=0 or DRAIN with result_pending=1: m_y_data <= fir_y_n, m_y_valid <= 1 next cycle, clear result_pending.
  - Latency: sample accepted at GET_DATA cycle T gives m_y_valid at T+7.
  - Exactly one strobe per streamed sample; no strobe for the DRAIN cycle's dummy sample.
- Back-to-back throughput: one sample per 6 cycles when upstream keeps the register full.

Test Plan:
- Reset release, s_valid asserted at cycle 0 → fir_tvalid stays 0 until BOOT ends. First ARM cycle at 5; first fir_x_n sampled (GET_DATA) at cycle 6.
- Default taps (-3, 2, 3), single sample x=1 then no more → DRAIN follows p=5. m_y_valid pulses once with m_y_data = -3, 7 cycles after GET_DATA. fir_tvalid returns to 0 and busy drops.
- cfg_req with c0=1, c1=0, c2=0 → fir_set_coeffs high for exactly 3 cycles. fir_x_n sequence 0, 0, 0, 1. cfg_done follows one cycle after CFG_TAIL. Then sample x=5 → m_y_data = 5.
- Continuous stream 10, 20, 30 with s_valid always high → GET_DATA cycles exactly 6 apart, s_ready low between consumes. Three m_y_valid pulses 6 cycles apart; no idle gap between frames.
- cfg_req raised mid-stream → fir_set_coeffs stays 0 until after DRAIN; loading completes afterwards; no lost or duplicated result strobe.
- reset asserted at STREAM p=3 with the register full → next cycle all outputs 0 and s_ready = 1. BOOT restarts; no m_y_valid for the aborted sample.
